// File: rtl/fir_sample_delay_line.sv
// rtl/fir_sample_delay_line.sv - parametrised FIR input delay line streaming TAPS samples per input
//
// Ports:
//   clk, rst                    single clock, asynchronous active-high reset
//   in_valid/in_ready/in_data   sample input handshake
//   tap_valid/tap_ready         tap output handshake
//   tap_data/tap_idx/tap_last   x[n-k], k (0 = newest), high with k == TAPS-1
//   busy                        high while clearing or scanning
//   flush                       present only when FIR_DL_FLUSH_EN is defined
//
// Optional feature macro: FIR_DL_FLUSH_EN (adds the flush input).
module fir_sample_delay_line #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 64,
    localparam int ADDR_W = $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              tap_valid,
    input  logic              tap_ready,
    output logic [DATA_W-1:0] tap_data,
    output logic [ADDR_W-1:0] tap_idx,
    output logic              tap_last,
`ifdef FIR_DL_FLUSH_EN
    input  logic              flush,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SCAN  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TAPS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  cnt;
    logic [ADDR_W-1:0]  wptr;
    logic [ADDR_W-1:0]  base;
    logic [ADDR_W-1:0]  nxt_idx;
    logic [ADDR_W-1:0]  rd_addr;
    logic               accept;
    logic               flush_req;
    logic [DATA_W-1:0]  mem [TAPS];

`ifdef FIR_DL_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Address of the next tap to present; base - k wraps modulo TAPS by width.
    assign nxt_idx = tap_idx + ADDR_W'(1);
    assign rd_addr = base - nxt_idx;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_CLEAR: begin
                // busy is forced low while rst is held so every output reads 0 in reset
                busy = !rst;
                if (cnt == LAST_IDX) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                in_ready = !flush_req;
                accept   = in_valid && !flush_req;
                if (flush_req) begin
                    state_nxt = ST_CLEAR;
                end else if (in_valid) begin
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                busy = 1'b1;
                if (flush_req) begin
                    state_nxt = ST_CLEAR;
                end else if (tap_valid && tap_ready && tap_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_CLEAR;
            cnt       <= '0;
            wptr      <= '0;
            base      <= '0;
            tap_valid <= 1'b0;
            tap_data  <= '0;
            tap_idx   <= '0;
            tap_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_CLEAR: begin
                    // wraps back to 0 on the final clear cycle, ready for the next clear
                    cnt <= cnt + ADDR_W'(1);
                end
                ST_IDLE: begin
                    if (flush_req) begin
                        wptr <= '0;
                        cnt  <= '0;
                    end else if (accept) begin
                        base      <= wptr;
                        wptr      <= wptr + ADDR_W'(1);
                        tap_valid <= 1'b1;
                        // tap 0 is the sample being written this edge, so bypass the array
                        tap_data  <= in_data;
                        tap_idx   <= '0;
                        tap_last  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (flush_req) begin
                        wptr      <= '0;
                        cnt       <= '0;
                        tap_valid <= 1'b0;
                        tap_data  <= '0;
                        tap_idx   <= '0;
                        tap_last  <= 1'b0;
                    end else if (tap_valid && tap_ready) begin
                        if (tap_last) begin
                            tap_valid <= 1'b0;
                            tap_data  <= '0;
                            tap_idx   <= '0;
                            tap_last  <= 1'b0;
                        end else begin
                            tap_idx  <= nxt_idx;
                            tap_data <= mem[rd_addr];
                            tap_last <= (nxt_idx == LAST_IDX);
                        end
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Storage has no reset; the CLEAR sweep zeroes it after every reset or flush.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[cnt] <= '0;
        end else if (accept) begin
            mem[wptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_fir_sample_delay_line.sv
// tb/tb_fir_sample_delay_line.sv - randomized self-checking bench for fir_sample_delay_line
module tb_fir_sample_delay_line;

    localparam int TAPS = 64;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        tap_valid;
    logic        tap_ready;
    logic [15:0] tap_data;
    logic [5:0]  tap_idx;
    logic        tap_last;
    logic        busy;
    logic        flush;

    int checks = 0;
    int errors = 0;

    logic [15:0] cap [TAPS];
    int          ntaps;
    int          nlast;
    logic [15:0] stall_data;

    fir_sample_delay_line #(.DATA_W(16), .TAPS(TAPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .tap_valid (tap_valid),
        .tap_ready (tap_ready),
        .tap_data  (tap_data),
        .tap_idx   (tap_idx),
        .tap_last  (tap_last),
`ifdef FIR_DL_FLUSH_EN
        .flush     (flush),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: every sample accepted since the last clear, oldest first.
    logic [15:0] hist [$];
    int          clear_left = TAPS;
    bit          scanning   = 0;
    int          exp_k      = 0;

    function automatic logic [15:0] exp_tap(input int k);
        if (k < hist.size()) return hist[hist.size() - 1 - k];
        return 16'h0;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            check({in_ready, busy, tap_valid, tap_last, tap_idx, tap_data} == '0, "reset_out",
                  {in_ready, busy, tap_valid, tap_last, tap_idx, tap_data}, 0);
            hist.delete();
            clear_left = TAPS;
            scanning   = 0;
            exp_k      = 0;
        end else begin
            check({in_ready, busy, tap_valid} ==
                  {(clear_left == 0) && !scanning && !flush, (clear_left > 0) || scanning, scanning},
                  "ctrl", {in_ready, busy, tap_valid},
                  {(clear_left == 0) && !scanning && !flush, (clear_left > 0) || scanning, scanning});
            if (scanning) begin
                check({tap_last, tap_idx, tap_data} == {exp_k == TAPS - 1, 6'(exp_k), exp_tap(exp_k)},
                      "tap", {tap_last, tap_idx, tap_data},
                      {exp_k == TAPS - 1, 6'(exp_k), exp_tap(exp_k)});
            end
            if (flush && clear_left == 0) begin
                hist.delete();
                clear_left = TAPS;
                scanning   = 0;
            end else if (clear_left > 0) begin
                clear_left--;
            end else if (scanning) begin
                if (tap_ready) begin
                    if (exp_k == TAPS - 1) scanning = 0;
                    else exp_k++;
                end
            end else if (in_valid) begin
                hist.push_back(in_data);
                scanning = 1;
                exp_k    = 0;
            end
        end
    end

    // All tasks start and end at posedge + 1.
    task automatic wait_clear(input string name);
        int n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        check(n == TAPS && !busy, name, {n, busy}, {TAPS, 1'b0});
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [15:0] d);
        int g = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (g < 300) begin
            @(negedge clk);
            if (in_ready) break;
            g++;
            @(posedge clk); #1;
        end
        check(g < 300, "send_timeout", g, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic collect_scan(input int stall_idx, input bit rnd);
        int guard = 0;
        bit stalled = 0;
        logic [15:0] held;
        ntaps = 0;
        nlast = 0;
        for (int i = 0; i < TAPS; i++) cap[i] = 16'hdead;
        while (guard < 2000) begin
            guard++;
            if (stall_idx >= 0 && !stalled && tap_valid && tap_idx == 6'(stall_idx)) begin
                stalled    = 1;
                tap_ready  = 1'b0;
                held       = tap_data;
                stall_data = held;
                repeat (3) begin
                    @(negedge clk);
                    check(tap_valid && tap_idx == 6'(stall_idx) && tap_data == held, "stall_hold",
                          {tap_valid, tap_idx, tap_data}, {1'b1, 6'(stall_idx), held});
                    @(posedge clk); #1;
                end
                tap_ready = 1'b1;
            end else if (rnd) begin
                tap_ready = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            if (tap_valid && tap_ready) begin
                ntaps++;
                cap[tap_idx] = tap_data;
                if (tap_last) begin
                    nlast++;
                    @(posedge clk); #1;
                    break;
                end
            end
            @(posedge clk); #1;
        end
        tap_ready = 1'b1;
        check(ntaps == TAPS && nlast == 1, "scan_count", {ntaps, nlast}, {TAPS, 1});
    endtask

    function automatic bit rest_zero();
        for (int i = 1; i < TAPS; i++) if (cap[i] != 16'h0) return 0;
        return 1;
    endfunction

    initial begin
        #5000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        tap_ready = 1'b1;
        flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Post-reset clear length
        wait_clear("clear_len_reset");

        // Single sample into a cleared line
        send(16'd100);
        collect_scan(-1, 0);
        check(cap[0] == 16'd100 && rest_zero(), "single_100", cap[0], 100);
        @(negedge clk);
        check(in_ready == 1'b1, "ready_after_last", in_ready, 1);
        @(posedge clk); #1;

        // Wrap-around: samples 1..65
        for (int s = 1; s <= 65; s++) begin
            send(16'(s));
            collect_scan(-1, 1);
        end
        check(cap[0] == 16'd65 && cap[1] == 16'd64 && cap[63] == 16'd2, "wrap",
              {cap[0], cap[1], cap[63]}, {16'd65, 16'd64, 16'd2});

        // Backpressure stall at tap 5
        send(16'd500);
        collect_scan(5, 0);
        check(stall_data == 16'd61 && cap[5] == 16'd61 && cap[0] == 16'd500, "stall_data",
              {stall_data, cap[5], cap[0]}, {16'd61, 16'd61, 16'd500});

        // Random traffic
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            send(16'($urandom));
            collect_scan(-1, 1);
        end

        // Reset in the middle of a scan
        send(16'd9);
        begin
            int g = 0;
            while (!(tap_valid && tap_idx == 6'd10) && g < 200) begin
                @(posedge clk); #1;
                g++;
            end
            check(g < 200, "reach_idx10", g, 0);
        end
        #2 rst = 1'b1;
        #1;
        check({tap_valid, tap_idx, tap_data, tap_last} == '0, "async_reset",
              {tap_valid, tap_idx, tap_data, tap_last}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_clear("clear_len_midrst");
        send(16'd7);
        collect_scan(-1, 0);
        check(cap[0] == 16'd7 && rest_zero(), "after_rst_7", cap[0], 7);

`ifdef FIR_DL_FLUSH_EN
        // Flush wins over a simultaneous sample
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h1234;
        @(negedge clk);
        check(in_ready == 1'b0, "flush_blocks", in_ready, 0);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        wait_clear("clear_len_flush");
        send(16'd3);
        collect_scan(-1, 0);
        check(cap[0] == 16'd3 && rest_zero(), "after_flush", cap[0], 3);
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
